// File: rtl/sid_env_pkg.sv
// Shared types and helpers for the time-multiplexed ADSR envelope sequencer.
package sid_env_pkg;

    localparam int unsigned RATE_BASE   = 9;
    localparam int unsigned ENV_W       = 4;
    localparam int unsigned RATE_W      = 4;
    localparam int unsigned PRESC_MAX_W = 32;
    localparam logic [ENV_W-1:0] ENV_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_DECAY   = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    // Tick when the low (rate+RATE_BASE) prescaler bits, clamped to its width, are all ones:
    // one step every 2^(rate+RATE_BASE) rounds.
    function automatic logic rate_tick(input logic [RATE_W-1:0]      rate,
                                       input logic [PRESC_MAX_W-1:0] presc,
                                       input int unsigned            presc_w);
        int unsigned            n;
        logic [PRESC_MAX_W-1:0] ones;
        n = 32'(rate) + RATE_BASE;
        if (n > presc_w) n = presc_w;
        ones = (n >= PRESC_MAX_W) ? '1 : (PRESC_MAX_W'(1) << n) - PRESC_MAX_W'(1);
        return (presc & ones) == ones;
    endfunction

endpackage

// File: rtl/sid_env_step.sv
// Combinational ADSR step for the voice currently owning the shared datapath.
// Optional build macro SID_ENV_HARD_RESTART_EN: any rising gate restarts attack from level 0.
module sid_env_step
    import sid_env_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 23
) (
    input  env_state_e             state,
    input  logic [ENV_W-1:0]       level,
    input  logic                   gate,
    input  logic                   last_gate,
    input  logic [RATE_W-1:0]      rate,
    input  logic [ENV_W-1:0]       sustain,
    input  logic [PRESCALE_W-1:0]  prescaler,
    output env_state_e             state_nxt_c,
    output logic [ENV_W-1:0]       level_nxt_c
);

    logic rise;
    logic tick;

    assign rise = gate & ~last_gate;
    assign tick = rate_tick(rate, PRESC_MAX_W'(prescaler), PRESCALE_W);

    // Next state / level with saturating 4-bit arithmetic.
    always_comb begin
        state_nxt_c = state;
        level_nxt_c = level;
`ifdef SID_ENV_HARD_RESTART_EN
        if (rise) begin
            state_nxt_c = ST_ATTACK;
            level_nxt_c = '0;
        end else
`endif
        case (state)
            ST_IDLE: begin
                level_nxt_c = '0;
                if (rise) state_nxt_c = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (!gate)                 state_nxt_c = ST_RELEASE;
                else if (level == ENV_MAX) state_nxt_c = ST_DECAY;
                else if (tick)             level_nxt_c = level + ENV_W'(1);
            end
            ST_DECAY: begin
                if (!gate)                        state_nxt_c = ST_RELEASE;
                else if (level > sustain && tick) level_nxt_c = level - ENV_W'(1);
            end
            ST_RELEASE: begin
                if (rise)              state_nxt_c = ST_ATTACK;
                else if (level == '0)  state_nxt_c = ST_IDLE;
                else if (tick)         level_nxt_c = level - ENV_W'(1);
            end
            default: state_nxt_c = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/sid_env_sequencer.sv
// Round-robin envelope controller: one voice evaluated per clock through a shared step datapath.
// Optional build macro SID_ENV_HARD_RESTART_EN (handled in sid_env_step).
module sid_env_sequencer
    import sid_env_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned PRESCALE_W = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_VOICES-1:0]         gate,
    input  logic [NUM_VOICES*ENV_W-1:0]   attack_rate,
    input  logic [NUM_VOICES*ENV_W-1:0]   decay_rate,
    input  logic [NUM_VOICES*ENV_W-1:0]   sustain_value,
    input  logic [NUM_VOICES*ENV_W-1:0]   release_rate,
    output logic [NUM_VOICES*ENV_W-1:0]   env_out,
    output logic                          upd_strobe,
    output logic [$clog2(NUM_VOICES)-1:0] upd_voice
);

    localparam int unsigned SLOT_W = $clog2(NUM_VOICES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_VOICES - 1);

    logic [SLOT_W-1:0]     slot;
    logic [PRESCALE_W-1:0] prescaler;
    logic [NUM_VOICES-1:0] last_gate;
    env_state_e            state_q [NUM_VOICES];
    logic [ENV_W-1:0]      level_q [NUM_VOICES];

    logic [RATE_W-1:0] atk_n [NUM_VOICES];
    logic [RATE_W-1:0] dcy_n [NUM_VOICES];
    logic [RATE_W-1:0] rel_n [NUM_VOICES];
    logic [ENV_W-1:0]  sus_n [NUM_VOICES];

    env_state_e        cur_state;
    logic [ENV_W-1:0]  cur_level;
    logic [RATE_W-1:0] cur_rate;
    logic [ENV_W-1:0]  cur_sus;
    env_state_e        nxt_state;
    logic [ENV_W-1:0]  nxt_level;

    // Unpack register-file nibbles and expose the level registers.
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign atk_n[v] = attack_rate[v*ENV_W +: ENV_W];
        assign dcy_n[v] = decay_rate[v*ENV_W +: ENV_W];
        assign rel_n[v] = release_rate[v*ENV_W +: ENV_W];
        assign sus_n[v] = sustain_value[v*ENV_W +: ENV_W];
        assign env_out[v*ENV_W +: ENV_W] = level_q[v];
    end

    // Select the slot owner's context and the rate matching its phase.
    always_comb begin
        cur_state = state_q[slot];
        cur_level = level_q[slot];
        cur_sus   = sus_n[slot];
        cur_rate  = rel_n[slot];
        case (cur_state)
            ST_ATTACK: cur_rate = atk_n[slot];
            ST_DECAY:  cur_rate = dcy_n[slot];
            default:   cur_rate = rel_n[slot];
        endcase
    end

    sid_env_step #(
        .PRESCALE_W (PRESCALE_W)
    ) u_step (
        .state       (cur_state),
        .level       (cur_level),
        .gate        (gate[slot]),
        .last_gate   (last_gate[slot]),
        .rate        (cur_rate),
        .sustain     (cur_sus),
        .prescaler   (prescaler),
        .state_nxt_c (nxt_state),
        .level_nxt_c (nxt_level)
    );

    // Slot/prescaler advance and write-back of the evaluated voice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            prescaler  <= '0;
            last_gate  <= '0;
            state_q    <= '{default: ST_IDLE};
            level_q    <= '{default: '0};
            upd_strobe <= 1'b0;
            upd_voice  <= '0;
        end else begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
            if (slot == SLOT_LAST) prescaler <= prescaler + PRESCALE_W'(1);
            state_q[slot]   <= nxt_state;
            level_q[slot]   <= nxt_level;
            last_gate[slot] <= gate[slot];
            upd_strobe      <= 1'b1;
            upd_voice       <= slot;
        end
    end

endmodule

// File: tb/tb_sid_env_sequencer.sv
// Self-checking bench for sid_env_sequencer against a cycle/round-count reference model.
module tb_sid_env_sequencer;

    localparam int NV = 3;
    localparam int PW = 23;
    localparam int EW = 4;
    localparam int VW = $clog2(NV);
    localparam int OW = NV*EW + 1 + VW;
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_REL = 3;

    logic               clk;
    logic               rst_n;
    logic [NV-1:0]      gate;
    logic [NV*EW-1:0]   attack_rate, decay_rate, sustain_value, release_rate;
    logic [NV*EW-1:0]   env_out;
    logic               upd_strobe;
    logic [VW-1:0]      upd_voice;

    int     mph   [NV];
    int     mlev  [NV];
    bit     mlast [NV];
    longint cyc;
    bit     mstb;
    int     mvoice;
    int     vectors = 0;
    int     errors  = 0;

    sid_env_sequencer #(.NUM_VOICES(NV), .PRESCALE_W(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_value (sustain_value),
        .release_rate  (release_rate),
        .env_out       (env_out),
        .upd_strobe    (upd_strobe),
        .upd_voice     (upd_voice)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A rate-r step happens once every 2^(r+9) rounds, clamped to the prescaler period.
    function automatic bit tb_tick(int r, longint rnd);
        int     n;
        longint period;
        n = (r + 9 < PW) ? r + 9 : PW;
        period = longint'(1) << n;
        return (rnd % period) == period - 1;
    endfunction

    function automatic logic [OW-1:0] m_out();
        logic [NV*EW-1:0] e;
        e = '0;
        for (int v = 0; v < NV; v++) e[v*EW +: EW] = EW'(mlev[v]);
        return {e, mstb, VW'(mvoice)};
    endfunction

    function automatic logic [NV*EW-1:0] sel_mask(int v);
        logic [NV*EW-1:0] m;
        m = '0;
        for (int i = 0; i < NV; i++) if (i == v) m[i*EW +: EW] = '1;
        return m;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mph[v] = P_IDLE; mlev[v] = 0; mlast[v] = 1'b0;
        end
        cyc = 0; mstb = 1'b0; mvoice = 0;
    endtask

    // Apply the envelope rules to the voice whose turn it is at the coming edge.
    task automatic model_eval();
        int     v, ar, dr, sr, rr;
        longint rnd;
        bit     g, rise;
        v    = int'(cyc % NV);
        rnd  = cyc / NV;
        g    = gate[v];
        rise = g && !mlast[v];
        ar = int'(attack_rate[v*EW +: EW]);
        dr = int'(decay_rate[v*EW +: EW]);
        sr = int'(sustain_value[v*EW +: EW]);
        rr = int'(release_rate[v*EW +: EW]);
`ifdef SID_ENV_HARD_RESTART_EN
        if (rise) begin
            mph[v] = P_ATT; mlev[v] = 0;
        end else
`endif
        case (mph[v])
            P_IDLE: begin
                mlev[v] = 0;
                if (rise) mph[v] = P_ATT;
            end
            P_ATT: begin
                if (!g)                 mph[v] = P_REL;
                else if (mlev[v] == 15) mph[v] = P_DEC;
                else if (tb_tick(ar, rnd)) mlev[v] = mlev[v] + 1;
            end
            P_DEC: begin
                if (!g) mph[v] = P_REL;
                else if (mlev[v] > sr && tb_tick(dr, rnd)) mlev[v] = mlev[v] - 1;
            end
            default: begin
                if (rise)              mph[v] = P_ATT;
                else if (mlev[v] == 0) mph[v] = P_IDLE;
                else if (tb_tick(rr, rnd)) mlev[v] = mlev[v] - 1;
            end
        endcase
        mlast[v] = g;
        mstb     = 1'b1;
        mvoice   = v;
        cyc++;
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gate = '0;
        attack_rate = '0; decay_rate = '0; sustain_value = '0; release_rate = '0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({env_out, upd_strobe, upd_voice} !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got env=%h stb=%b v=%0d, want all zero", i, env_out, upd_strobe, upd_voice);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        bit bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL idle cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
        end
    endtask

    task automatic test_attack();
        bit               bad = 0, loc_bad = 0, iv_bad = 0;
        logic [NV*EW-1:0] prev;
        longint           t0, last_up = -1, t15 = -1;
        int               ups0 = 0, ups2 = 0, n = 0;
        attack_rate = 12'h400; decay_rate = 12'h001; sustain_value = 12'hF06; release_rate = 12'h000;
        while (cyc % NV != 0) step();
        gate = 3'b101;
        t0 = cyc;
        prev = env_out;
        while (mph[0] != P_DEC && n < 26000) begin
            step(); n++;
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL attack cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
            if (!loc_bad) begin
                vectors++;
                if ((env_out & ~sel_mask(int'(upd_voice))) !== (prev & ~sel_mask(int'(upd_voice)))) begin
                    errors++; loc_bad = 1;
                    $display("FAIL locality cyc=%0d: env %h prev %h upd_voice %0d", cyc, env_out, prev, upd_voice);
                end
            end
            if (env_out[3:0] !== prev[3:0]) begin
                ups0++;
                if (last_up >= 0 && !iv_bad) begin
                    vectors++;
                    if (cyc - last_up != 1536) begin
                        errors++; iv_bad = 1;
                        $display("FAIL attack_interval: got %0d clocks want 1536", cyc - last_up);
                    end
                end
                last_up = cyc;
                if (env_out[3:0] == 4'hF && t15 < 0) t15 = cyc - t0;
            end
            if (env_out[11:8] !== prev[11:8]) ups2++;
            prev = env_out;
        end
        vectors++;
        if (n >= 26000) begin errors++; $display("FAIL attack_timeout: voice 0 never reached decay"); end
        vectors++;
        if (ups0 != 15) begin errors++; $display("FAIL attack_steps: got %0d want 15", ups0); end
        vectors++;
        if (t15 < 21500 || t15 > 24576) begin errors++; $display("FAIL attack_time: got %0d want 21500..24576", t15); end
        vectors++;
        if (ups2 > 1) begin errors++; $display("FAIL slow_voice_steps: got %0d want <=1", ups2); end
        vectors++;
        if (env_out[7:4] !== 4'h0) begin errors++; $display("FAIL ungated_voice: got %h want 0", env_out[7:4]); end
    endtask

    task automatic test_decay();
        bit               bad = 0, iv_bad = 0;
        logic [NV*EW-1:0] prev;
        longint           last_dn = -1;
        int               downs = 0, held = 0, n = 0;
        prev = env_out;
        while (held < 3500 && n < 32000) begin
            step(); n++;
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL decay cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
            if (env_out[3:0] !== prev[3:0]) begin
                downs++;
                if (last_dn >= 0 && !iv_bad) begin
                    vectors++;
                    if (cyc - last_dn != 3072) begin
                        errors++; iv_bad = 1;
                        $display("FAIL decay_interval: got %0d clocks want 3072", cyc - last_dn);
                    end
                end
                last_dn = cyc;
            end
            if (mlev[0] == 6) held++;
            prev = env_out;
        end
        vectors++;
        if (n >= 32000) begin errors++; $display("FAIL decay_timeout: sustain not reached"); end
        vectors++;
        if (downs != 9) begin errors++; $display("FAIL decay_steps: got %0d want 9", downs); end
        vectors++;
        if (env_out[3:0] !== 4'h6) begin errors++; $display("FAIL sustain_hold: got %h want 6", env_out[3:0]); end
    endtask

    task automatic test_release_retrigger();
        bit         bad = 0;
        int         n = 0;
        logic [3:0] want_a, want_b;
`ifdef SID_ENV_HARD_RESTART_EN
        want_a = 4'h0; want_b = 4'h1;
`else
        want_a = 4'h3; want_b = 4'h4;
`endif
        gate[0] = 1'b0;
        while (mlev[0] != 3 && n < 8000) begin
            step(); n++;
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL release cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
        end
        vectors++;
        if (n >= 8000) begin errors++; $display("FAIL release_timeout: level 3 never reached"); end
        gate[0] = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL retrigger cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
            if (i == 2) begin
                vectors++;
                if (env_out[3:0] !== want_a) begin errors++; $display("FAIL retrigger_start: got %h want %h", env_out[3:0], want_a); end
            end
        end
        vectors++;
        if (env_out[3:0] !== want_b) begin errors++; $display("FAIL retrigger_ramp: got %h want %h", env_out[3:0], want_b); end
    endtask

    task automatic test_async_reset();
        bit bad = 0;
        #3;
        rst_n = 1'b0;
        gate  = '0;
        #1;
        vectors++;
        if ({env_out, upd_strobe, upd_voice} !== '0) begin
            errors++;
            $display("FAIL async_reset: got env=%h stb=%b v=%0d, want all zero", env_out, upd_strobe, upd_voice);
        end
        model_reset();
        attack_rate = '0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            if (i == 400) gate = 3'b010;
            step();
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL post_reset cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
            if (i == 399) begin
                vectors++;
                if (env_out !== '0) begin errors++; $display("FAIL stays_idle: got %h want 0", env_out); end
            end
        end
        vectors++;
        if (env_out !== 12'h010) begin errors++; $display("FAIL fresh_attack: got %h want 010", env_out); end
    endtask

    task automatic test_random();
        bit bad = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 1500 == 0) begin
                attack_rate   = (NV*EW)'($urandom) & {NV{4'h1}};
                decay_rate    = (NV*EW)'($urandom) & {NV{4'h1}};
                release_rate  = (NV*EW)'($urandom) & {NV{4'h1}};
                sustain_value = (NV*EW)'($urandom);
            end
            if ($urandom_range(299) == 0) gate = gate ^ (NV'(1) << $urandom_range(NV - 1));
            step();
            if (!bad) begin
                vectors++;
                if ({env_out, upd_strobe, upd_voice} !== m_out()) begin
                    errors++; bad = 1;
                    $display("FAIL random cyc=%0d: got %h want %h", cyc, {env_out, upd_strobe, upd_voice}, m_out());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_attack();
        test_decay();
        test_release_retrigger();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
